pipelined_addsub: RTL and testbench

- Parametrised, pipelined successor to the combinational ripple-carry adder. Adds or subtracts two WIDTH-bit operands.
- The carry chain is split into STAGES equal chunks, one register stage per chunk. Each stage resolves its chunk using the carry registered from the stage before it.
- Uses a valid/ready handshake with full backpressure. Produces sum, carry, signed overflow and zero flags for the 8-bit ALU datapath.

---
 rtl/pipelined_addsub_if.sv | 27 ++
 rtl/pipelined_addsub.sv | 98 +++++++++
 tb/tb_pipelined_addsub.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_addsub_if.sv
// Handshake bundle for the pipelined adder/subtractor: operand beat in, result beat out.
`timescale 1ns/1ps
interface pipelined_addsub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow, zero
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the carry chain is cut into STAGES chunks, one register rank per chunk,
// behind an operand capture rank, with a single global advance for full backpressure.
`timescale 1ns/1ps
module pipelined_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic              clk,
  input logic              rst,
  pipelined_addsub_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  logic              advance;

  // rank k holds operands plus the low k chunks already resolved
  logic [STAGES-1:0] vld_p;
  logic [WIDTH-1:0]  a_p  [STAGES];
  logic [WIDTH-1:0]  bx_p [STAGES];
  logic [WIDTH-1:0]  s_p  [STAGES];
  logic [STAGES-1:0] c_p;

  logic [WIDTH-1:0]  ns [STAGES];
  logic [STAGES-1:0] nc;

  logic              vld_pf;
  logic [WIDTH-1:0]  sum_pf;
  logic              cout_pf;
  logic              ovf_pf;
  logic              zero_pf;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             cin);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign advance       = !vld_pf || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pf;
  assign bus.sum       = sum_pf;
  assign bus.carry_out = cout_pf;
  assign bus.overflow  = ovf_pf;
  assign bus.zero      = zero_pf;

  // chunk k of rank k is resolved combinationally from the carry registered in rank k
  always_comb begin
    logic [CHUNK:0] csum;
    csum = '0;
    nc   = '0;
    for (int k = 0; k < STAGES; k++) begin
      csum  = chunk_add(a_p[k][k*CHUNK +: CHUNK], bx_p[k][k*CHUNK +: CHUNK], c_p[k]);
      ns[k] = s_p[k];
      ns[k][k*CHUNK +: CHUNK] = csum[CHUNK-1:0];
      nc[k] = csum[CHUNK];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p   <= '0;
      vld_pf  <= 1'b0;
      sum_pf  <= '0;
      cout_pf <= 1'b0;
      ovf_pf  <= 1'b0;
      zero_pf <= 1'b0;
    end else if (advance) begin
      vld_p[0] <= bus.in_valid;
      for (int k = 1; k < STAGES; k++) vld_p[k] <= vld_p[k-1];
      // final rank: full sum and flags
      vld_pf  <= vld_p[STAGES-1];
      sum_pf  <= ns[STAGES-1];
      cout_pf <= nc[STAGES-1];
      ovf_pf  <= signed_ovf(a_p[STAGES-1][WIDTH-1], bx_p[STAGES-1][WIDTH-1],
                            ns[STAGES-1][WIDTH-1]);
      zero_pf <= (ns[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      a_p[0]  <= bus.a;
      bx_p[0] <= bus.sub ? ~bus.b : bus.b;
      c_p[0]  <= bus.sub;
      s_p[0]  <= '0;
      for (int k = 1; k < STAGES; k++) begin
        a_p[k]  <= a_p[k-1];
        bx_p[k] <= bx_p[k-1];
        s_p[k]  <= ns[k-1];
        c_p[k]  <= nc[k-1];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, streaming, backpressure, mid-flight reset, random traffic.
`timescale 1ns/1ps
module tb_pipelined_addsub;
  localparam int WIDTH  = 8;
  localparam int STAGES = 2;
  localparam longint MODV = longint'(1) << WIDTH;
  localparam longint SMAX = MODV / 2 - 1;
  localparam longint SMIN = -(MODV / 2);

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c;
    logic             v;
    logic             z;
  } res_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] sum;
    logic       c;
    logic       v;
    logic       z;
  } vec_t;

  res_t exp_q[$];

  vec_t dirv [8] = '{
    '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1},
    '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0},
    '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0},
    '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0},
    '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0},
    '{8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1},
    '{8'h08, 8'h08, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0}
  };

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic s);
    longint ua, ub, full, sa, sb, sr;
    res_t   r;
    ua    = longint'(a);
    ub    = longint'(b);
    full  = s ? ua - ub : ua + ub;
    r.sum = full[WIDTH-1:0];
    r.c   = s ? (ua >= ub) : (full >= MODV);
    sa    = (ua > SMAX) ? ua - MODV : ua;
    sb    = (ub > SMAX) ? ub - MODV : ub;
    sr    = s ? sa - sb : sa + sb;
    r.v   = (sr > SMAX) || (sr < SMIN);
    r.z   = (r.sum == '0);
    return r;
  endfunction

  // Scoreboard: every accepted beat must leave once, in order, with the model's result
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid), 64'd0);
        end else if (bus.out_ready) begin
          res_t e;
          e = exp_q.pop_front();
          chk("sb_sum", 64'(bus.sum), 64'(e.sum));
          chk("sb_carry", 64'(bus.carry_out), 64'(e.c));
          chk("sb_ovf", 64'(bus.overflow), 64'(e.v));
          chk("sb_zero", 64'(bus.zero), 64'(e.z));
        end else begin
          chk("hold_sum", 64'(bus.sum), 64'(exp_q[0].sum));
          chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.sub));
    end
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic s);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
  endtask

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(posedge clk);
    #1 drive(a, b, s);
    @(negedge clk);
    chk("accept_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen
  task automatic wait_out(output int k);
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic stream(input logic stall);
    @(posedge clk);
    #1 drive(8'h01, 8'h01, 1'b0);
    @(posedge clk);
    #1 drive(8'h02, 8'h02, 1'b0);
    @(posedge clk);
    #1 drive(8'h03, 8'h03, 1'b0);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (stall) begin
      bus.out_ready = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("stall_valid", 64'(bus.out_valid), 64'd1);
        chk("stall_sum", 64'(bus.sum), 64'h02);
        chk("stall_ready", 64'(bus.in_ready), 64'd0);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk("stream_valid", 64'(bus.out_valid), 64'd1);
      chk("stream_sum", 64'(bus.sum), 64'(2 * i));
    end
    @(negedge clk);
    chk("stream_end", 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_carry", 64'(bus.carry_out), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    chk("rst_zero", 64'(bus.zero), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    foreach (dirv[i]) begin
      send_one(dirv[i].a, dirv[i].b, dirv[i].s);
      wait_out(k);
      chk("dir_latency", 64'(k), 64'(STAGES));
      chk("dir_sum", 64'(bus.sum), 64'(dirv[i].sum));
      chk("dir_carry", 64'(bus.carry_out), 64'(dirv[i].c));
      chk("dir_ovf", 64'(bus.overflow), 64'(dirv[i].v));
      chk("dir_zero", 64'(bus.zero), 64'(dirv[i].z));
      @(negedge clk);
      chk("dir_one_cycle", 64'(bus.out_valid), 64'd0);
    end

    stream(1'b0);
    stream(1'b1);

    @(posedge clk);
    #1 drive(8'h11, 8'h22, 1'b0);
    @(posedge clk);
    #1 drive(8'h33, 8'h01, 1'b1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_flush", 64'(bus.out_valid), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("midrst_flush", 64'(bus.out_valid), 64'd0);
    end
    send_one(8'h10, 8'h20, 1'b0);
    wait_out(k);
    chk("midrst_latency", 64'(k), 64'(STAGES));
    chk("midrst_sum", 64'(bus.sum), 64'h30);

    repeat (400) begin
      @(posedge clk);
      #1;
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.a         = WIDTH'($urandom);
      bus.b         = WIDTH'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_valid", 64'(bus.out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
